conv_stream_collector: RTL and testbench

- Receiving end of the convolution output stream: accepts one qualified pixel per cycle from the edge-detection pipeline (no backpressure on that side) and tracks output-image geometry (ROW_SIZE-2 columns by NUM_ROWS-2 rows).
- Buffers pixels in a FIFO and re-emits them on a ready/valid interface tagged with start/end-of-line and start/end-of-frame markers, for downstream DMA or display logic.

---
 rtl/conv_stream_collector_if.sv | 30 +++
 rtl/conv_stream_collector.sv | 186 ++++++++++++++++++
 tb/tb_conv_stream_collector.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_stream_collector_if.sv
// Stream bundle between the convolution pipeline, the collector and its downstream consumer.
// The collector drives the output side through the master modport.
interface conv_stream_collector_if #(
  parameter int WORD_SIZE = 8
);
  logic [WORD_SIZE-1:0] inputPixel;
  logic [1:0]           inputValid;
  logic [WORD_SIZE-1:0] out_pixel;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sol;
  logic                 out_eol;
  logic                 out_sof;
  logic                 out_eof;
  logic                 overflow;
  logic                 clear_overflow;
  logic                 frame_done;

  modport master (
    input  inputPixel, inputValid, out_ready, clear_overflow,
    output out_pixel, out_valid, out_sol, out_eol, out_sof, out_eof,
           overflow, frame_done
  );

  modport slave (
    output inputPixel, inputValid, out_ready, clear_overflow,
    input  out_pixel, out_valid, out_sol, out_eol, out_sof, out_eof,
           overflow, frame_done
  );
endinterface

// File: rtl/conv_stream_collector.sv
// Collects convolution output pixels, tags them with line/frame markers and buffers
// them in a show-ahead FIFO for a ready/valid consumer.
module conv_stream_collector #(
  parameter int WORD_SIZE  = 8,
  parameter int ROW_SIZE   = 540,
  parameter int NUM_ROWS   = 540,
  parameter int FIFO_DEPTH = 16
) (
  input logic clk,
  input logic rst_n,
  conv_stream_collector_if.master bus
);

  localparam int OUT_COLS = ROW_SIZE - 2;
  localparam int OUT_ROWS = NUM_ROWS - 2;
  localparam int COL_W    = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int ROW_W    = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENTRY_W  = WORD_SIZE + 4;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(OUT_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(OUT_ROWS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  logic [ENTRY_W-1:0] fifoMem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   writePtr_q, writePtr_d;
  logic [PTR_W-1:0]   readPtr_q, readPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;

  logic               beat;
  logic               beatSol, beatEol, beatSof, beatEof;
  logic [ENTRY_W-1:0] pushEntry;
  logic [ENTRY_W-1:0] headEntry;
  logic               headEof;
  logic               fifoValid, fifoFull;
  logic               push, pop, drop;
  logic               frameDone;
  logic               unusedValidBit;

  // Only bit 0 of inputValid qualifies a pixel; bit 1 carries no meaning here.
  assign beat           = bus.inputValid[0];
  assign unusedValidBit = bus.inputValid[1];

  assign beatSol   = (col_q == '0);
  assign beatEol   = (col_q == LAST_COL);
  assign beatSof   = (col_q == '0) && (row_q == '0);
  assign beatEof   = (col_q == LAST_COL) && (row_q == LAST_ROW);
  assign pushEntry = {beatSol, beatEol, beatSof, beatEof, bus.inputPixel};

  assign headEntry = fifoMem_q[readPtr_q];
  assign headEof   = headEntry[WORD_SIZE];
  assign fifoValid = (count_q != '0);
  assign fifoFull  = (count_q == FULL_CNT);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop  = fifoValid && bus.out_ready;
  assign push = beat && (!fifoFull || pop);
  assign drop = beat && fifoFull && !pop;

  // Geometry advances on every qualified beat, dropped or not, so markers stay aligned.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (beat) begin
      if (beatEof) begin
        col_d = '0;
        row_d = '0;
      end else if (beatEol) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_comb begin
    writePtr_d = writePtr_q;
    readPtr_d  = readPtr_q;
    count_d    = count_q;
    if (push) writePtr_d = writePtr_q + PTR_W'(1);
    if (pop)  readPtr_d  = readPtr_q + PTR_W'(1);
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // A drop in the same cycle as a clear request wins so no loss goes unreported.
  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifoMem_q[i] <= '0;
    end else if (push) begin
      fifoMem_q[writePtr_q] <= pushEntry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      writePtr_q <= '0;
      readPtr_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      writePtr_q <= writePtr_d;
      readPtr_q  <= readPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame tracking never throttles input: beats seen during DRAIN already belong to the next frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (beat) state_d = beatEof ? DRAIN : ACTIVE;
      end
      ACTIVE: begin
        if (beat && beatEof) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && headEof) begin
          if (beat && beatEof) begin
            state_d = DRAIN;
          end else if (beat || (col_q != '0) || (row_q != '0)) begin
            state_d = ACTIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frameDone = 1'b0;
    if (pop && headEof) frameDone = 1'b1;
  end

  assign bus.out_valid  = fifoValid;
  assign bus.out_pixel  = headEntry[WORD_SIZE-1:0];
  assign bus.out_sol    = fifoValid && headEntry[WORD_SIZE+3];
  assign bus.out_eol    = fifoValid && headEntry[WORD_SIZE+2];
  assign bus.out_sof    = fifoValid && headEntry[WORD_SIZE+1];
  assign bus.out_eof    = fifoValid && headEntry[WORD_SIZE];
  assign bus.overflow   = overflow_q;
  assign bus.frame_done = frameDone;

endmodule

// File: tb/tb_conv_stream_collector.sv
// Scoreboard bench for conv_stream_collector: a frame-index reference model queues expected
// entries at each clock edge and a negedge monitor compares them as the DUT presents its head.
module tb_conv_stream_collector;

  localparam int WORD_SIZE   = 8;
  localparam int ROW_SIZE    = 6;
  localparam int NUM_ROWS    = 5;
  localparam int FIFO_DEPTH  = 4;
  localparam int OUT_COLS    = ROW_SIZE - 2;
  localparam int FRAME_BEATS = OUT_COLS * (NUM_ROWS - 2);

  typedef struct {
    logic [WORD_SIZE-1:0] pixel;
    logic                 sol;
    logic                 eol;
    logic                 sof;
    logic                 eof;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;

  conv_stream_collector_if #(.WORD_SIZE(WORD_SIZE)) bus ();

  conv_stream_collector #(
    .WORD_SIZE (WORD_SIZE),
    .ROW_SIZE  (ROW_SIZE),
    .NUM_ROWS  (NUM_ROWS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  entry_t expQ[$];
  entry_t newEntry;
  entry_t headExp;
  int     frameIdx     = 0;
  logic   expOverflow  = 1'b0;
  logic   droppedNow;
  logic   expValid;
  logic   expFrameDone;
  int     frameDoneSeen = 0;
  int     testsRun      = 0;
  int     testsFailed   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid, input logic [WORD_SIZE-1:0] pixel,
                               input logic ready, input logic clr);
    @(posedge clk);
    #1;
    bus.inputValid     = valid;
    bus.inputPixel     = pixel;
    bus.out_ready      = ready;
    bus.clear_overflow = clr;
  endtask

  task automatic drainAll();
    int cycles = 0;
    while (expQ.size() != 0 && cycles < 40) begin
      applyStimulus(2'b00, '0, 1'b1, 1'b0);
      cycles++;
    end
    applyStimulus(2'b00, '0, 1'b1, 1'b0);
    checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  // Reference model: a beat's markers follow from its index within the frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expQ.delete();
      frameIdx    = 0;
      expOverflow = 1'b0;
    end else begin
      droppedNow = 1'b0;
      if (bus.inputValid[0] === 1'b1) begin
        newEntry.pixel = bus.inputPixel;
        newEntry.sol   = (frameIdx % OUT_COLS) == 0;
        newEntry.eol   = (frameIdx % OUT_COLS) == OUT_COLS - 1;
        newEntry.sof   = (frameIdx == 0);
        newEntry.eof   = (frameIdx == FRAME_BEATS - 1);
        frameIdx       = (frameIdx + 1) % FRAME_BEATS;
        if (expQ.size() < FIFO_DEPTH) expQ.push_back(newEntry);
        else droppedNow = 1'b1;
      end
      if (droppedNow) expOverflow = 1'b1;
      else if (bus.clear_overflow === 1'b1) expOverflow = 1'b0;
    end
  end

  // Monitor: the head is consumed at the next rising edge when ready is high.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      expValid = (expQ.size() != 0);
      checkOutput("out_valid", bus.out_valid, expValid);
      checkOutput("overflow", bus.overflow, expOverflow);
      expFrameDone = 1'b0;
      if (expValid) begin
        headExp = expQ[0];
        checkOutput("out_pixel", bus.out_pixel, headExp.pixel);
        checkOutput("flags", {bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof},
                    {headExp.sol, headExp.eol, headExp.sof, headExp.eof});
        expFrameDone = bus.out_ready && headExp.eof;
      end else begin
        checkOutput("flags_empty", {bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof}, 0);
      end
      checkOutput("frame_done", bus.frame_done, expFrameDone);
      if (bus.frame_done === 1'b1) frameDoneSeen++;
      if (expValid && bus.out_ready === 1'b1) void'(expQ.pop_front());
    end
  end

  initial begin
    rst_n              = 1'b1;
    bus.inputValid     = 2'b00;
    bus.inputPixel     = '0;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs",
                {bus.out_valid, bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof,
                 bus.overflow, bus.frame_done}, 0);
    checkOutput("reset_pixel", bus.out_pixel, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // One full frame streamed straight through.
    for (int i = 1; i <= FRAME_BEATS; i++) applyStimulus(2'b01, WORD_SIZE'(i), 1'b1, 1'b0);
    drainAll();
    checkOutput("frame_done_count", frameDoneSeen, 1);

    // Fill while stalled, overflow on the fifth beat, then drain in order.
    for (int i = 10; i <= 14; i++) applyStimulus(2'b01, WORD_SIZE'(i), 1'b0, 1'b0);
    applyStimulus(2'b00, '0, 1'b0, 1'b0);
    checkOutput("overflow_after_drop", bus.overflow, 1);
    checkOutput("held_head", bus.out_pixel, 10);
    drainAll();
    for (int i = 5; i < FRAME_BEATS; i++) applyStimulus(2'b01, WORD_SIZE'($urandom), 1'b1, 1'b0);
    applyStimulus(2'b01, WORD_SIZE'($urandom), 1'b1, 1'b0);
    applyStimulus(2'b00, '0, 1'b1, 1'b1);
    applyStimulus(2'b00, '0, 1'b1, 1'b0);
    checkOutput("overflow_cleared", bus.overflow, 0);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(2'b01, WORD_SIZE'($urandom), 1'b0, 1'b0);
    applyStimulus(2'b01, 8'hA5, 1'b1, 1'b0);
    applyStimulus(2'b00, '0, 1'b0, 1'b0);
    checkOutput("overflow_on_pop_push", bus.overflow, 0);
    drainAll();

    // Clear request colliding with a drop, then a clean clear.
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus(2'b01, WORD_SIZE'($urandom), 1'b0, 1'b0);
    applyStimulus(2'b01, WORD_SIZE'($urandom), 1'b0, 1'b1);
    applyStimulus(2'b00, '0, 1'b0, 1'b1);
    checkOutput("overflow_set_beats_clear", bus.overflow, 1);
    applyStimulus(2'b00, '0, 1'b0, 1'b0);
    checkOutput("overflow_late_clear", bus.overflow, 0);
    drainAll();

    // Asynchronous reset between edges after seven beats.
    for (int i = 0; i < 7; i++) applyStimulus(2'b01, WORD_SIZE'(40 + i), 1'b0, 1'b0);
    applyStimulus(2'b00, '0, 1'b0, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", bus.out_valid, 0);
    checkOutput("async_reset_flags",
                {bus.out_sol, bus.out_eol, bus.out_sof, bus.out_eof, bus.overflow}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Qualified beats interleaved with 2'b10 / 2'b00 idles; first is sof, twelfth is eof.
    for (int i = 0; i < FRAME_BEATS; i++) begin
      applyStimulus(2'b01, WORD_SIZE'(100 + i), 1'b1, 1'b0);
      applyStimulus(2'b10, WORD_SIZE'($urandom), 1'b1, 1'b0);
      if (i % 3 == 0) applyStimulus(2'b00, WORD_SIZE'($urandom), 1'b1, 1'b0);
    end
    drainAll();

    // Randomized traffic with random backpressure and occasional clears.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), WORD_SIZE'($urandom),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    drainAll();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
